// File: rtl/finalsoc_ocm_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port on-chip RAM.
// Reads return one cycle after grant, routed back to the owning port.
module finalsoc_ocm_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  input  logic [DATA_W-1:0]     mem_readdata,
  input  logic                  contention_clear,
  output logic [CNT_W-1:0]      contention_count
);

  logic w_req0, w_req1, w_gnt0, w_gnt1;
  logic r_last_grant, r_rd_valid, r_rd_owner;
  logic [CNT_W-1:0] r_cnt;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // r_last_grant = 1 means m1 was served last, so m0 wins the next contention.
  assign w_gnt0 = ~reset & w_req0 & (~w_req1 | r_last_grant);
  assign w_gnt1 = ~reset & w_req1 & (~w_req0 | ~r_last_grant);

  assign m0_waitrequest = w_req0 & ~w_gnt0;
  assign m1_waitrequest = w_req1 & ~w_gnt1;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (w_gnt0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
    end else if (w_gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
    end
  end

  // Gating with reset drops a read whose data would land in a reset cycle.
  assign m0_readdatavalid = r_rd_valid & ~r_rd_owner & ~reset;
  assign m1_readdatavalid = r_rd_valid &  r_rd_owner & ~reset;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
  assign contention_count = r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_rd_valid   <= 1'b0;
      r_rd_owner   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_gnt0)
        r_last_grant <= 1'b0;
      else if (w_gnt1)
        r_last_grant <= 1'b1;
      r_rd_valid <= (w_gnt0 & ~m0_write) | (w_gnt1 & ~m1_write);
      r_rd_owner <= w_gnt1;
      if (contention_clear)
        r_cnt <= '0;
      else if (w_req0 && w_req1 && (r_cnt != '1))
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_finalsoc_ocm_arbiter.sv
// Directed bench for finalsoc_ocm_arbiter: a cycle model predicts grants and
// strobes, and a read scoreboard predicts returned data from a shadow memory.
module tb_finalsoc_ocm_arbiter;
  localparam int AW = 2;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_address, m1_address;
  logic [3:0]    m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic [DW-1:0] mem_writedata;
  logic          mem_chipselect, mem_write;
  logic [DW-1:0] mem_readdata;
  logic          contention_clear;
  logic [CW-1:0] contention_count;

  finalsoc_ocm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_readdata(mem_readdata),
    .contention_clear(contention_clear), .contention_count(contention_count)
  );

  always #5 clk = ~clk;

  // Single-port RAM with byte lanes and one-cycle read latency.
  logic [DW-1:0] ram [4];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  typedef struct { bit port; logic [DW-1:0] data; } rd_t;
  rd_t           sb[$];
  logic [DW-1:0] sh [4];
  bit            m_last = 1'b1;
  int unsigned   m_cnt = 0;
  int            errors = 0;
  int            checks = 0;
  int            nv0 = 0, nv1 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input bit r, input bit w, input logic [AW-1:0] a,
                      input logic [3:0] be, input logic [DW-1:0] d);
    m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic set1(input bit r, input bit w, input logic [AW-1:0] a,
                      input logic [3:0] be, input logic [DW-1:0] d);
    m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle();
    set0(0, 0, '0, '0, '0);
    set1(0, 0, '0, '0, '0);
  endtask

  // One cycle: check outputs against the model, then advance the model and clock.
  task automatic tick();
    bit q0, q1, g0, g1, ev0, ev1, ew;
    logic [DW-1:0] ed0, ed1, wd;
    logic [AW-1:0] ea;
    logic [3:0] eb;
    rd_t e;
    #1;
    q0 = m0_read | m0_write;
    q1 = m1_read | m1_write;
    ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
    if (reset) sb.delete();
    else if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.port) begin ev1 = 1; ed1 = e.data; end
      else begin ev0 = 1; ed0 = e.data; end
    end
    if (m0_readdatavalid) nv0++;
    if (m1_readdatavalid) nv1++;
    chk("m0_rdv", m0_readdatavalid, ev0);
    chk("m1_rdv", m1_readdatavalid, ev1);
    chk("m0_rdata", m0_readdata, ed0);
    chk("m1_rdata", m1_readdata, ed1);
    g0 = !reset && q0 && (!q1 || m_last);
    g1 = !reset && q1 && !g0;
    chk("m0_wait", m0_waitrequest, q0 && !g0);
    chk("m1_wait", m1_waitrequest, q1 && !g1);
    ew = 0; ea = '0; eb = '0; wd = '0;
    if (g0) begin ew = m0_write; ea = m0_address; eb = m0_byteenable; wd = m0_writedata; end
    if (g1) begin ew = m1_write; ea = m1_address; eb = m1_byteenable; wd = m1_writedata; end
    chk("mem_cs", mem_chipselect, g0 || g1);
    chk("mem_wr", mem_write, ew);
    chk("mem_addr", mem_address, ea);
    chk("mem_be", mem_byteenable, eb);
    chk("mem_wdata", mem_writedata, wd);
    chk("cnt", contention_count, m_cnt);
    if (g0 || g1) begin
      if (ew) begin
        for (int b = 0; b < 4; b++)
          if (eb[b]) sh[ea][8*b +: 8] = wd[8*b +: 8];
      end else begin
        sb.push_back('{port: g1, data: sh[ea]});
      end
    end
    if (reset) m_last = 1;
    else if (g0) m_last = 0;
    else if (g1) m_last = 1;
    if (reset || contention_clear) m_cnt = 0;
    else if (q0 && q1 && m_cnt != 15) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) sh[i] = '0;
    reset = 1; contention_clear = 0; idle();
    @(posedge clk); #1;
    tick();
    reset = 0;

    // single-requester write then read
    set0(0, 1, 2, 4'hF, 32'hDEADBEEF); tick();
    set0(1, 0, 2, 4'hF, '0);           tick();
    idle();                            tick();

    // partial byte write over existing word
    set0(0, 1, 1, 4'hF, 32'hAAAAAAAA); tick();
    set0(0, 1, 1, 4'h3, 32'h11223344); tick();
    set0(1, 0, 1, 4'hF, '0);           tick();
    idle();                            tick();
    chk("be_merge", sh[1], 32'hAAAA3344);

    // read+write on m1 is a write
    set1(1, 1, 3, 4'hF, 32'h55667788); tick();
    idle();                            tick();
    set1(1, 0, 3, 4'hF, '0);           tick();
    idle();                            tick();

    // sustained contention after reset: alternating grants
    reset = 1; tick(); reset = 0;
    nv0 = 0; nv1 = 0;
    set0(1, 0, 2, 4'hF, '0);
    set1(1, 0, 1, 4'hF, '0);
    for (int i = 0; i < 6; i++) tick();
    chk("cnt6", contention_count, 6);
    idle(); tick();
    chk("m0_nvalid", nv0, 3);
    chk("m1_nvalid", nv1, 3);

    // reset right after a read grant drops the read
    set0(1, 0, 2, 4'hF, '0); tick();
    idle(); reset = 1;       tick();
    reset = 0;
    set0(1, 0, 2, 4'hF, '0);
    set1(1, 0, 1, 4'hF, '0); tick();
    idle();                  tick();

    // saturation and clear priority
    reset = 1; tick(); reset = 0;
    set0(0, 1, 0, 4'hF, 32'h01020304);
    set1(0, 1, 3, 4'hF, 32'hCAFEF00D);
    for (int i = 0; i < 17; i++) tick();
    chk("cnt_sat", contention_count, 15);
    contention_clear = 1; tick();
    contention_clear = 0; idle(); tick();
    chk("cnt_clr", contention_count, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/finalsoc_ocm_arbiter.md
FINALSOC_OCM_ARBITER -- requirements
Module: finalsoc_ocm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 2, SHALL set the word-address width of both requester ports and of the memory port.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; byteenable width SHALL be DATA_W/8.
REQ-003 Parameter CNT_W, default 16, SHALL set the contention counter width.
REQ-004 clk  in  1  SHALL be the single clock; every register updates on its rising edge.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-006 mX_address  in  ADDR_W  SHALL be the requester X word address (X = 0, 1; each port is a separate signal).
REQ-007 mX_byteenable  in  DATA_W/8  SHALL be the requester X byte lanes.
REQ-008 mX_read  in  1  SHALL be the requester X read request.
REQ-009 mX_write  in  1  SHALL be the requester X write request.
REQ-010 mX_writedata  in  DATA_W  SHALL be the requester X write data.
REQ-011 mX_waitrequest  out  1  SHALL be the requester X stall, meaning the request was not accepted this cycle.
REQ-012 mX_readdata  out  DATA_W  SHALL be the requester X read data.
REQ-013 mX_readdatavalid  out  1  SHALL qualify mX_readdata.
REQ-014 mem_address, mem_byteenable, mem_writedata  out  ADDR_W, DATA_W/8, DATA_W  SHALL drive the single-port RAM.
REQ-015 mem_chipselect, mem_write  out  1, 1  SHALL be the RAM access strobe and the RAM write strobe.
REQ-016 mem_readdata  in  DATA_W  SHALL be the RAM output, valid in the cycle after the address is presented.
REQ-017 contention_clear  in  1  SHALL synchronously zero contention_count.
REQ-018 contention_count  out  CNT_W  SHALL hold the count of cycles in which both requesters were requesting.

Function
REQ-019 reqX SHALL equal mX_read | mX_write.
- If mX_read and mX_write are both high, the access SHALL be a write and the read SHALL be ignored.
REQ-020 At most one grant SHALL be issued per cycle, combinationally from the current inputs.
- If only one requester is requesting, that requester SHALL be granted.
- If both are requesting, the grant SHALL go to the requester that is not last_grant.
REQ-021 last_grant SHALL be a 1-bit register that is updated to the granted index only on cycles with a grant; it SHALL hold its value otherwise.
REQ-022 mX_waitrequest SHALL equal reqX & ~grantX.
- The requester SHALL hold its request stable until waitrequest is low.
- A requester that is not requesting SHALL see waitrequest = 0.
REQ-023 When a grant is issued:
- mem_chipselect SHALL be 1 and mem_write SHALL equal the granted write.
- mem_address, mem_byteenable and mem_writedata SHALL be muxed from the granted port.
- With no grant, all mem_* outputs SHALL be 0.
REQ-024 A granted read in cycle N SHALL set the registered rd_valid = 1 and rd_owner = X for cycle N+1.
- In cycle N+1, mX_readdatavalid SHALL be 1 for exactly one cycle and mX_readdata SHALL equal mem_readdata.
- The readdata and readdatavalid of the non-owner port SHALL be 0.
REQ-025 Reads SHALL be fully pipelined, with one accepted read per cycle, sustained.
- Read latency SHALL be exactly 1 cycle, with no gap between back-to-back reads, including when the owner alternates.
REQ-026 A write in cycle N followed by a read of the same address in cycle N+1 SHALL return the new data; write-then-read ordering is preserved by the serialization.
REQ-027 contention_count SHALL increment by 1 on every cycle with req0 & req1.
- It SHALL saturate at all-ones and SHALL NOT wrap.
- contention_clear SHALL take priority over an increment in the same cycle.

Reset
REQ-028 While reset = 1, all grants SHALL be suppressed; every waitrequest SHALL follow its reqX; all mem_* outputs SHALL be 0.
REQ-029 On reset:
- last_grant SHALL be set to 1, so that m0 wins the first contention.
- rd_valid SHALL be 0 and contention_count SHALL be 0.
REQ-030 A reset asserted in the cycle after a read grant SHALL suppress that readdatavalid; the pending read SHALL be dropped and not replayed.

Verification
REQ-031 Only m0 writes 0xDEADBEEF to address 2 with byteenable 0xF, then reads address 2 -> no waitrequest; m0_readdatavalid is 1 one cycle after the read, with data 0xDEADBEEF.
REQ-032 m0 and m1 both read continuously for 6 cycles after reset -> grants alternate m0,m1,m0,...; each waitrequest is high on alternate cycles; each port sees 3 readdatavalids; contention_count = 6.
REQ-033 m0 writes 0x11223344 to address 1 with byteenable 0x3 over an existing 0xAAAAAAAA, then reads it -> returns 0xAAAA3344.
REQ-034 Read and write both asserted on m1 to address 3 -> write performed, no readdatavalid.
REQ-035 m0 read is granted, then reset is asserted the next cycle -> no readdatavalid; after reset, m0 wins the first contention and contention_count = 0.
REQ-036 contention_count preloaded to all-ones by forcing contention for 2^CNT_W cycles (CNT_W = 4 in the bench) -> count holds at 15; clear together with contention -> count becomes 0.
